// File: rtl/nf_10g_if_stats_pkg.sv
// rtl/nf_10g_if_stats_pkg.sv - shared encodings and constants for the 10G interface statistics stage
package nf_10g_if_stats_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;

  localparam int DBG_RX_WRAP   = 0;
  localparam int DBG_TX_WRAP   = 1;
  localparam int DBG_RX_IN_PKT = 2;
  localparam int DBG_TX_IN_PKT = 3;

  localparam logic [31:0] FLIP_RESET = 32'hFFFF_FFFF;

  function automatic logic [31:0] pack_status(
    input logic rx_wrap,
    input logic tx_wrap,
    input logic rx_in_pkt,
    input logic tx_in_pkt
  );
    logic [31:0] s;
    s = '0;
    s[DBG_RX_WRAP]   = rx_wrap;
    s[DBG_TX_WRAP]   = tx_wrap;
    s[DBG_RX_IN_PKT] = rx_in_pkt;
    s[DBG_TX_IN_PKT] = tx_in_pkt;
    return s;
  endfunction

endpackage

// File: rtl/nf_10g_if_pkt_counter.sv
// rtl/nf_10g_if_pkt_counter.sv - per-direction packet FSM, clearable counter and sticky wrap flag (NF_10G_IF_STATS_SATURATE_EN selects saturation)
module nf_10g_if_pkt_counter
  import nf_10g_if_stats_pkg::*;
#(
  parameter int C_COUNTER_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       tvalid,
  input  logic                       tready,
  input  logic                       tlast,
  input  logic                       clear,
  input  logic                       wrap_clear,
  output logic [C_COUNTER_WIDTH-1:0] count,
  output logic                       in_pkt,
  output logic                       wrap
);

  localparam logic [C_COUNTER_WIDTH-1:0] ONE = C_COUNTER_WIDTH'(1);

  pkt_state_t state;
  logic       beat;
  logic       inc;
  logic       at_max;
  logic       wrap_set;

  assign beat     = tvalid & tready;
  assign inc      = beat & tlast;
  assign at_max   = &count;
  // A clear in the same cycle restarts the count, so it can never overflow.
  assign wrap_set = inc & ~clear & at_max;
  assign in_pkt   = (state == ST_IN_PKT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (beat && !tlast) state <= ST_IN_PKT;
        ST_IN_PKT: if (beat && tlast)  state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      if (clear) begin
        count <= inc ? ONE : '0;
      end else if (inc) begin
        if (!at_max) count <= count + ONE;
`ifdef NF_10G_IF_STATS_SATURATE_EN
        else count <= count;
`else
        else count <= '0;
`endif
      end

      if (wrap_set) wrap <= 1'b1;
      else if (wrap_clear) wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/nf_10g_if_stats.sv
// rtl/nf_10g_if_stats.sv - RX/TX packet counters, flip loopback and status word (NF_10G_IF_STATS_SATURATE_EN selects saturating counters)
module nf_10g_if_stats
  import nf_10g_if_stats_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_COUNTER_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rx_tvalid,
  input  logic                       rx_tready,
  input  logic                       rx_tlast,
  input  logic                       tx_tvalid,
  input  logic                       tx_tready,
  input  logic                       tx_tlast,
  input  logic                       counterin_reg_clear,
  input  logic                       counterout_reg_clear,
  input  logic [31:0]                cpu2ip_flip_reg,
  input  logic [31:0]                cpu2ip_debug_reg,
  output logic [C_COUNTER_WIDTH-1:0] counterin_reg,
  output logic [C_COUNTER_WIDTH-1:0] counterout_reg,
  output logic [31:0]                ip2cpu_flip_reg,
  output logic [31:0]                ip2cpu_debug_reg
);

  // Only the handshake is snooped; the keep width is kept for interface parity.
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  logic [KEEP_W-1:0] unused_keep;
  logic              unused_debug;
  logic              dbg0_q;
  logic              wrap_clear;
  logic              rx_in_pkt;
  logic              tx_in_pkt;
  logic              rx_wrap;
  logic              tx_wrap;

  assign unused_keep  = '0;
  assign unused_debug = ^cpu2ip_debug_reg[31:1];
  assign wrap_clear   = cpu2ip_debug_reg[0] & ~dbg0_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ip2cpu_flip_reg <= FLIP_RESET;
      dbg0_q          <= 1'b0;
    end else begin
      ip2cpu_flip_reg <= ~cpu2ip_flip_reg;
      dbg0_q          <= cpu2ip_debug_reg[0];
    end
  end

  nf_10g_if_pkt_counter #(
    .C_COUNTER_WIDTH(C_COUNTER_WIDTH)
  ) u_rx_counter (
    .clk        (clk),
    .resetn     (resetn),
    .tvalid     (rx_tvalid),
    .tready     (rx_tready),
    .tlast      (rx_tlast),
    .clear      (counterin_reg_clear),
    .wrap_clear (wrap_clear),
    .count      (counterin_reg),
    .in_pkt     (rx_in_pkt),
    .wrap       (rx_wrap)
  );

  nf_10g_if_pkt_counter #(
    .C_COUNTER_WIDTH(C_COUNTER_WIDTH)
  ) u_tx_counter (
    .clk        (clk),
    .resetn     (resetn),
    .tvalid     (tx_tvalid),
    .tready     (tx_tready),
    .tlast      (tx_tlast),
    .clear      (counterout_reg_clear),
    .wrap_clear (wrap_clear),
    .count      (counterout_reg),
    .in_pkt     (tx_in_pkt),
    .wrap       (tx_wrap)
  );

  assign ip2cpu_debug_reg = pack_status(rx_wrap, tx_wrap, rx_in_pkt, tx_in_pkt);

endmodule

// File: tb/tb_nf_10g_if_stats.sv
// tb/tb_nf_10g_if_stats.sv - directed self-checking bench for nf_10g_if_stats
module tb_nf_10g_if_stats;

  localparam int W = 4;
`ifdef NF_10G_IF_STATS_SATURATE_EN
  localparam logic [31:0] OVF_COUNT = 32'd15;
`else
  localparam logic [31:0] OVF_COUNT = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         rx_tvalid, rx_tready, rx_tlast;
  logic         tx_tvalid, tx_tready, tx_tlast;
  logic         counterin_reg_clear, counterout_reg_clear;
  logic [31:0]  cpu2ip_flip_reg, cpu2ip_debug_reg;
  logic [W-1:0] counterin_reg, counterout_reg;
  logic [31:0]  ip2cpu_flip_reg, ip2cpu_debug_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nf_10g_if_stats #(
    .C_S_AXIS_DATA_WIDTH(64),
    .C_COUNTER_WIDTH    (W)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .rx_tvalid            (rx_tvalid),
    .rx_tready            (rx_tready),
    .rx_tlast             (rx_tlast),
    .tx_tvalid            (tx_tvalid),
    .tx_tready            (tx_tready),
    .tx_tlast             (tx_tlast),
    .counterin_reg_clear  (counterin_reg_clear),
    .counterout_reg_clear (counterout_reg_clear),
    .cpu2ip_flip_reg      (cpu2ip_flip_reg),
    .cpu2ip_debug_reg     (cpu2ip_debug_reg),
    .counterin_reg        (counterin_reg),
    .counterout_reg       (counterout_reg),
    .ip2cpu_flip_reg      (ip2cpu_flip_reg),
    .ip2cpu_debug_reg     (ip2cpu_debug_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rx_idle();
    rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic rx_pkts(input int n);
    for (int i = 0; i < n; i++) begin
      rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = 1'b1;
      tick();
    end
    rx_idle();
  endtask

  task automatic rx_clear();
    counterin_reg_clear = 1'b1;
    tick();
    counterin_reg_clear = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    rx_idle();
    tx_tvalid = 1'b0; tx_tready = 1'b0; tx_tlast = 1'b0;
    counterin_reg_clear = 1'b0; counterout_reg_clear = 1'b0;
    cpu2ip_flip_reg = 32'h1234_5678;
    cpu2ip_debug_reg = 32'h0;
    tick(); tick();
    check("reset_counterin", 32'(counterin_reg), 32'd0);
    check("reset_counterout", 32'(counterout_reg), 32'd0);
    check("reset_flip", ip2cpu_flip_reg, 32'hFFFF_FFFF);
    check("reset_debug", ip2cpu_debug_reg, 32'h0);

    resetn = 1'b1;
    cpu2ip_flip_reg = 32'h0000_FFFF;
    tick();
    check("flip_inverse", ip2cpu_flip_reg, 32'hFFFF_0000);

    // Three 4-beat RX packets; a stalled cycle (tlast asserted) precedes every beat.
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        rx_tvalid = (b % 2 == 0); rx_tready = (b % 2 != 0); rx_tlast = 1'b1;
        tick();
        check("rx_in_pkt_gap", 32'(ip2cpu_debug_reg[2]), (b != 0) ? 32'd1 : 32'd0);
        rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = (b == 3);
        tick();
        check("rx_in_pkt_beat", 32'(ip2cpu_debug_reg[2]), (b != 3) ? 32'd1 : 32'd0);
      end
      rx_idle();
    end
    check("rx_three_pkts", 32'(counterin_reg), 32'd3);
    check("tx_untouched", 32'(counterout_reg), 32'd0);

    tx_tvalid = 1'b1; tx_tready = 1'b1; tx_tlast = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
    check("tx_five_single", 32'(counterout_reg), 32'd5);
    check("tx_in_pkt_low", 32'(ip2cpu_debug_reg[3]), 32'd0);

    rx_pkts(4);
    check("rx_seven", 32'(counterin_reg), 32'd7);
    counterin_reg_clear = 1'b1;
    rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = 1'b1;
    tick();
    counterin_reg_clear = 1'b0;
    rx_idle();
    check("clear_with_pkt", 32'(counterin_reg), 32'd1);
    rx_clear();
    check("clear_alone", 32'(counterin_reg), 32'd0);
    counterout_reg_clear = 1'b1;
    tick();
    counterout_reg_clear = 1'b0;
    check("tx_clear", 32'(counterout_reg), 32'd0);

    rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = 1'b1;
    tx_tvalid = 1'b1; tx_tlast = 1'b1;
    tick();
    rx_idle();
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
    check("both_rx", 32'(counterin_reg), 32'd1);
    check("both_tx", 32'(counterout_reg), 32'd1);

    rx_clear();
    rx_pkts(15);
    check("rx_at_max", 32'(counterin_reg), 32'd15);
    check("no_wrap_yet", ip2cpu_debug_reg, 32'h0);
    rx_pkts(1);
    check("rx_overflow", 32'(counterin_reg), OVF_COUNT);
    check("rx_wrap_set", ip2cpu_debug_reg, 32'h1);
    check("tx_unaffected", 32'(counterout_reg), 32'd1);

    cpu2ip_debug_reg = 32'h1;
    tick();
    check("wrap_cleared", ip2cpu_debug_reg, 32'h0);
    rx_clear();
    rx_pkts(16);
    check("wrap_again", ip2cpu_debug_reg, 32'h1);
    tick();
    check("held_bit0_no_reclear", ip2cpu_debug_reg, 32'h1);
    cpu2ip_debug_reg = 32'h0;
    tick();
    check("bit0_fall_keeps", ip2cpu_debug_reg, 32'h1);

    // Rising edge and a new wrap on the same edge: the wrap must win.
    rx_clear();
    rx_pkts(15);
    cpu2ip_debug_reg = 32'h1;
    rx_pkts(1);
    check("wrap_beats_clear", ip2cpu_debug_reg, 32'h1);
    tick();
    check("wrap_still_set", ip2cpu_debug_reg, 32'h1);
    cpu2ip_debug_reg = 32'h0;

    rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = 1'b0;
    tick(); tick();
    rx_idle();
    check("mid_pkt_in_pkt", 32'(ip2cpu_debug_reg[2]), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("reset_fsm_idle", ip2cpu_debug_reg, 32'h0);
    check("reset_count_zero", 32'(counterin_reg), 32'd0);
    rx_tvalid = 1'b1; rx_tready = 1'b1; rx_tlast = 1'b0;
    tick();
    rx_tlast = 1'b1;
    tick();
    rx_idle();
    check("tail_counted", 32'(counterin_reg), 32'd1);
    check("tail_idle", 32'(ip2cpu_debug_reg[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
